// File: rtl/hist_pkg.sv
// Shared types and sizing helpers for the TDC histogram peak engine.
// Imported by the engine top and its per-pixel bin banks.
package hist_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        OUT   = 2'd2
    } state_e;

    // Index width that stays at least one bit for degenerate counts
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pow2(input int w);
        return 1 << w;
    endfunction

    // Number of histogram bins for a timestamp width and bin shift
    function automatic int bins_of(input int np, input int sh);
        return pow2(np - sh);
    endfunction

    // All-ones timestamp marks a sample with no photon
    function automatic logic [31:0] no_hit(input int np);
        return (32'd1 << np) - 32'd1;
    endfunction

endpackage

// File: rtl/hist_bin_bank.sv
// Per-pixel bank of saturating bin counters with an increment port
// and a read-and-clear scan port that tracks the running peak.
module hist_bin_bank
    import hist_pkg::*;
#(
    parameter int BW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc_en,
    input  logic [BW-1:0]    inc_bin,
    input  logic             scan_en,
    input  logic [BW-1:0]    scan_idx,
    output logic [CNT_W-1:0] max_cnt,
    output logic [BW-1:0]    max_bin
);

    localparam int BINS = pow2(BW);
    localparam logic [CNT_W-1:0] SAT = '1;

    logic [CNT_W-1:0] cnt_q [BINS];
    logic [CNT_W-1:0] cnt_d [BINS];
    logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
    logic [BW-1:0]    max_bin_q, max_bin_d;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] ref_cnt;

    // Saturating increment, and zero each bin as the scan reads it
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && (cnt_q[inc_bin] != SAT)) begin
            cnt_d[inc_bin] = cnt_q[inc_bin] + 1'b1;
        end
        if (scan_en) begin
            cnt_d[scan_idx] = '0;
        end
    end

    // Running peak; strict greater-than keeps the lowest bin on ties
    always_comb begin
        rd_cnt    = cnt_q[scan_idx];
        ref_cnt   = (scan_idx == '0) ? '0 : max_cnt_q;
        max_cnt_d = max_cnt_q;
        max_bin_d = max_bin_q;
        if (scan_en) begin
            if (rd_cnt > ref_cnt) begin
                max_cnt_d = rd_cnt;
                max_bin_d = scan_idx;
            end else if (scan_idx == '0) begin
                max_cnt_d = '0;
                max_bin_d = '0;
            end
        end
    end

    // Counter and peak registers, cleared in parallel on reset
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q     <= '{default: '0};
            max_cnt_q <= '0;
            max_bin_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            max_cnt_q <= max_cnt_d;
            max_bin_q <= max_bin_d;
        end
    end

    assign max_cnt = max_cnt_q;
    assign max_bin = max_bin_q;

endmodule

// File: rtl/hist_peak_engine.sv
// Multi-pixel TDC histogram builder: accumulate, scan for peaks,
// then stream one peak record per pixel over valid/ready.
module hist_peak_engine
    import hist_pkg::*;
#(
    parameter int NP           = 10,
    parameter int BIN_SHIFT    = 2,
    parameter int PIXELS       = 3,
    parameter int ACQ_NUM      = 4,
    parameter int HITS_PER_ACQ = 2,
    parameter int CNT_W        = 8,
    localparam int PW          = idx_w(PIXELS)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [NP-1:0]    data,
    input  logic             win_en,
    input  logic [NP-1:0]    win_base,
    output logic             accepting,
    output logic             drop,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [PW-1:0]    peak_pixel,
    output logic [NP-1:0]    peak_time,
    output logic [CNT_W-1:0] peak_cnt,
    output logic             peak_empty
);

    localparam int BW   = NP - BIN_SHIFT;
    localparam int BINS = bins_of(NP, BIN_SHIFT);
    localparam int HW   = idx_w(HITS_PER_ACQ);
    localparam int AW   = idx_w(ACQ_NUM);
    localparam int SPAN = BINS << BIN_SHIFT;

    localparam logic [NP-1:0] SENT      = NP'(no_hit(NP));
    localparam logic [HW-1:0] HIT_LAST  = HW'(HITS_PER_ACQ - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS - 1);
    localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_NUM - 1);
    localparam logic [BW-1:0] SCAN_LAST = BW'(BINS - 1);
    localparam logic [NP:0]   WIN_SPAN  = SPAN[NP:0];

    state_e           state_q, state_d;
    logic [HW-1:0]    hit_q, hit_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic [AW-1:0]    acq_q, acq_d;
    logic [BW-1:0]    scan_q, scan_d;
    logic             win_q, win_d;
    logic [NP-1:0]    base_q, base_d;
    logic             accepting_q, accepting_d;
    logic             drop_q, drop_d;
    logic             peak_valid_q, peak_valid_d;
    logic [PW-1:0]    peak_pixel_q, peak_pixel_d;
    logic [NP-1:0]    peak_time_q, peak_time_d;
    logic [CNT_W-1:0] peak_cnt_q, peak_cnt_d;
    logic             peak_empty_q, peak_empty_d;

    logic             first_smp;
    logic             win_eff;
    logic [NP-1:0]    base_eff;
    logic [NP:0]      off;
    logic             in_win;
    logic             accept;
    logic             counted;
    logic [BW-1:0]    smp_bin;
    logic [PIXELS-1:0] inc_vec;
    logic             scan_en;

    logic [CNT_W-1:0] bank_cnt [PIXELS];
    logic [BW-1:0]    bank_bin [PIXELS];
    logic [PW-1:0]    rec_sel;
    logic [NP-1:0]    rec_time;
    logic [CNT_W-1:0] rec_cnt;

    // Classify the incoming sample against the active window
    always_comb begin
        first_smp = (hit_q == '0) && (pix_q == '0) && (acq_q == '0);
        win_eff   = first_smp ? win_en : win_q;
        base_eff  = first_smp ? win_base : base_q;
        off       = {1'b0, data} - {1'b0, base_eff};
        in_win    = !off[NP] && (off < WIN_SPAN);
        smp_bin   = win_eff ? off[NP-1:BIN_SHIFT] : data[NP-1:BIN_SHIFT];
        accept    = wr_en && (state_q == ACCUM);
        counted   = accept && (data != SENT) && (!win_eff || in_win);
        inc_vec   = '0;
        for (int p = 0; p < PIXELS; p++) begin
            inc_vec[p] = counted && (pix_q == PW'(p));
        end
        scan_en   = (state_q == SCAN);
    end

    for (genvar g = 0; g < PIXELS; g++) begin : g_bank
        hist_bin_bank #(
            .BW    (BW),
            .CNT_W (CNT_W)
        ) u_bank (
            .clk      (clk),
            .res      (res),
            .inc_en   (inc_vec[g]),
            .inc_bin  (smp_bin),
            .scan_en  (scan_en),
            .scan_idx (scan_q),
            .max_cnt  (bank_cnt[g]),
            .max_bin  (bank_bin[g])
        );
    end

    // Next record to present: pixel 0 on entry, else the one after
    always_comb begin
        rec_sel  = peak_valid_q ? peak_pixel_q + 1'b1 : '0;
        rec_cnt  = bank_cnt[rec_sel];
        rec_time = (NP'(bank_bin[rec_sel]) << BIN_SHIFT)
                 + (win_q ? base_q : '0);
    end

    // Sequencer: index walk, scan sweep and record handshake
    always_comb begin
        state_d      = state_q;
        hit_d        = hit_q;
        pix_d        = pix_q;
        acq_d        = acq_q;
        scan_d       = scan_q;
        win_d        = win_q;
        base_d       = base_q;
        accepting_d  = accepting_q;
        drop_d       = wr_en && (state_q != ACCUM);
        peak_valid_d = peak_valid_q;
        peak_pixel_d = peak_pixel_q;
        peak_time_d  = peak_time_q;
        peak_cnt_d   = peak_cnt_q;
        peak_empty_d = peak_empty_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (first_smp) begin
                        win_d  = win_en;
                        base_d = win_base;
                    end
                    hit_d = hit_q + 1'b1;
                    if (hit_q == HIT_LAST) begin
                        hit_d = '0;
                        pix_d = pix_q + 1'b1;
                        if (pix_q == PIX_LAST) begin
                            pix_d = '0;
                            acq_d = acq_q + 1'b1;
                            if (acq_q == ACQ_LAST) begin
                                acq_d       = '0;
                                scan_d      = '0;
                                state_d     = SCAN;
                                accepting_d = 1'b0;
                            end
                        end
                    end
                end
            end
            SCAN: begin
                scan_d = scan_q + 1'b1;
                if (scan_q == SCAN_LAST) begin
                    scan_d  = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (!peak_valid_q || peak_ready) begin
                    if (peak_valid_q && (peak_pixel_q == PIX_LAST)) begin
                        peak_valid_d = 1'b0;
                        state_d      = ACCUM;
                        accepting_d  = 1'b1;
                    end else begin
                        peak_valid_d = 1'b1;
                        peak_pixel_d = rec_sel;
                        peak_time_d  = rec_time;
                        peak_cnt_d   = rec_cnt;
                        peak_empty_d = (rec_cnt == '0);
                    end
                end
            end
            default: begin
                state_d     = ACCUM;
                accepting_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= ACCUM;
            hit_q        <= '0;
            pix_q        <= '0;
            acq_q        <= '0;
            scan_q       <= '0;
            win_q        <= 1'b0;
            base_q       <= '0;
            accepting_q  <= 1'b1;
            drop_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_pixel_q <= '0;
            peak_time_q  <= '0;
            peak_cnt_q   <= '0;
            peak_empty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            pix_q        <= pix_d;
            acq_q        <= acq_d;
            scan_q       <= scan_d;
            win_q        <= win_d;
            base_q       <= base_d;
            accepting_q  <= accepting_d;
            drop_q       <= drop_d;
            peak_valid_q <= peak_valid_d;
            peak_pixel_q <= peak_pixel_d;
            peak_time_q  <= peak_time_d;
            peak_cnt_q   <= peak_cnt_d;
            peak_empty_q <= peak_empty_d;
        end
    end

    assign accepting  = accepting_q;
    assign drop       = drop_q;
    assign peak_valid = peak_valid_q;
    assign peak_pixel = peak_pixel_q;
    assign peak_time  = peak_time_q;
    assign peak_cnt   = peak_cnt_q;
    assign peak_empty = peak_empty_q;

endmodule

// File: tb/tb_hist_peak_engine.sv
// Randomised bench for hist_peak_engine against a histogram model.
// A second instance with 2-bit counters exercises saturation.
module tb_hist_peak_engine;

    localparam int NP     = 10;
    localparam int PIXELS = 3;
    localparam int ACQ    = 4;
    localparam int HITS   = 2;
    localparam int BINS   = 256;
    localparam int NS     = ACQ * PIXELS * HITS;
    localparam int SENT   = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, wr_en, win_en, peak_ready;
    logic [NP-1:0] data, win_base;

    logic          accepting, drop, peak_valid, peak_empty;
    logic [1:0]    peak_pixel;
    logic [NP-1:0] peak_time;
    logic [7:0]    peak_cnt;

    logic          acc2, drop2, valid2, empty2;
    logic [1:0]    pix2;
    logic [NP-1:0] time2;
    logic [1:0]    cnt2;

    hist_peak_engine dut (
        .clk(clk), .res(res), .wr_en(wr_en), .data(data),
        .win_en(win_en), .win_base(win_base),
        .accepting(accepting), .drop(drop),
        .peak_valid(peak_valid), .peak_ready(peak_ready),
        .peak_pixel(peak_pixel), .peak_time(peak_time),
        .peak_cnt(peak_cnt), .peak_empty(peak_empty)
    );

    hist_peak_engine #(.CNT_W(2)) dut_sat (
        .clk(clk), .res(res), .wr_en(wr_en), .data(data),
        .win_en(win_en), .win_base(win_base),
        .accepting(acc2), .drop(drop2),
        .peak_valid(valid2), .peak_ready(peak_ready),
        .peak_pixel(pix2), .peak_time(time2),
        .peak_cnt(cnt2), .peak_empty(empty2)
    );

    int vectors = 0;
    int miscompares = 0;
    int smp [NS];
    int e_time [2][PIXELS];
    int e_cnt [2][PIXELS];
    int e_empty [PIXELS];
    bit exp_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sidx(int a, int p, int h);
        return (a * PIXELS + p) * HITS + h;
    endfunction

    // Reference: histogram per pixel, then peak per counter width
    task automatic model(input bit win, input int base);
        int h [BINS];
        int d, off, b, best, bb, c, sat;
        for (int p = 0; p < PIXELS; p++) begin
            for (int i = 0; i < BINS; i++) h[i] = 0;
            for (int a = 0; a < ACQ; a++) begin
                for (int k = 0; k < HITS; k++) begin
                    d = smp[sidx(a, p, k)];
                    if (d == SENT) continue;
                    if (win) begin
                        off = d - base;
                        if (off < 0 || off >= BINS * 4) continue;
                        b = off / 4;
                    end else begin
                        b = d / 4;
                    end
                    h[b]++;
                end
            end
            e_empty[p] = 1;
            for (int i = 0; i < BINS; i++) if (h[i] > 0) e_empty[p] = 0;
            for (int s = 0; s < 2; s++) begin
                sat = (s == 0) ? 255 : 3;
                best = 0;
                bb = 0;
                for (int i = 0; i < BINS; i++) begin
                    c = (h[i] < sat) ? h[i] : sat;
                    if (c > best) begin
                        best = c;
                        bb = i;
                    end
                end
                e_cnt[s][p] = best;
                e_time[s][p] = (bb * 4 + (win ? base : 0)) % 1024;
            end
        end
    endtask

    task automatic idle_checks();
        chk("drop", 32'(drop), 32'(exp_drop));
        chk("drop2", 32'(drop2), 32'(exp_drop));
        chk("accepting", 32'(accepting), 1);
        chk("accepting2", 32'(acc2), 1);
        chk("valid_idle", 32'(peak_valid), 0);
    endtask

    task automatic rst_checks();
        chk("rst_accepting", 32'(accepting), 1);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_valid", 32'(peak_valid), 0);
        chk("rst_pixel", 32'(peak_pixel), 0);
        chk("rst_time", 32'(peak_time), 0);
        chk("rst_cnt", 32'(peak_cnt), 0);
        chk("rst_empty", 32'(peak_empty), 0);
        chk("rst_valid2", 32'(valid2), 0);
    endtask

    task automatic send_hist(input bit win, input int base, input bit gaps);
        for (int i = 0; i < NS; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom % 3) begin
                    @(negedge clk);
                    idle_checks();
                    wr_en = 1'b0;
                    data = 10'($urandom);
                    exp_drop = 1'b0;
                end
            end
            @(negedge clk);
            idle_checks();
            wr_en = 1'b1;
            data = 10'(smp[i]);
            win_en = (i == 0) ? win : 1'($urandom);
            win_base = (i == 0) ? 10'(base) : 10'($urandom);
            exp_drop = 1'b0;
        end
    endtask

    task automatic collect(input bit bp, input bit drp);
        int cyc;
        int rec;
        int hold;
        int n;
        bit got;
        got = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("drop_busy", 32'(drop), 32'(exp_drop));
            if (peak_valid) begin
                got = 1'b1;
                break;
            end
            chk("acc_busy", 32'(accepting), 0);
            chk("valid2_busy", 32'(valid2), 0);
            wr_en = drp ? ($urandom % 4 == 0) : 1'b0;
            data = 10'($urandom);
            exp_drop = wr_en;
        end
        chk("latency", cyc, BINS + 1);
        rec = 0;
        hold = 0;
        n = 0;
        while (got && rec < PIXELS && n < 200) begin
            if (n > 0) begin
                @(negedge clk);
                chk("drop_out", 32'(drop), 32'(exp_drop));
            end
            n++;
            chk("valid", 32'(peak_valid), 1);
            chk("acc_out", 32'(accepting), 0);
            chk("pixel", 32'(peak_pixel), rec);
            chk("time", 32'(peak_time), e_time[0][rec]);
            chk("cnt", 32'(peak_cnt), e_cnt[0][rec]);
            chk("empty", 32'(peak_empty), e_empty[rec]);
            chk("valid2", 32'(valid2), 1);
            chk("pixel2", 32'(pix2), rec);
            chk("time2", 32'(time2), e_time[1][rec]);
            chk("cnt2", 32'(cnt2), e_cnt[1][rec]);
            chk("empty2", 32'(empty2), e_empty[rec]);
            if (bp && rec == 1 && hold < 5) begin
                peak_ready = 1'b0;
                hold++;
            end else begin
                peak_ready = bp ? 1'($urandom) : 1'b1;
            end
            wr_en = drp ? 1'($urandom) : 1'b0;
            data = 10'($urandom);
            exp_drop = wr_en;
            if (peak_ready) rec++;
        end
        chk("records", rec, PIXELS);
    endtask

    task automatic run(input bit win, input int base, input bit gaps,
                       input bit bp, input bit drp);
        model(win, base);
        send_hist(win, base, gaps);
        collect(bp, drp);
    endtask

    task automatic fill_sent();
        for (int i = 0; i < NS; i++) smp[i] = SENT;
    endtask

    task automatic fill_random();
        int tgt;
        int r;
        for (int p = 0; p < PIXELS; p++) begin
            tgt = $urandom % 1024;
            for (int a = 0; a < ACQ; a++) begin
                for (int k = 0; k < HITS; k++) begin
                    r = $urandom % 4;
                    if (r == 0) smp[sidx(a, p, k)] = SENT;
                    else if (r == 1) smp[sidx(a, p, k)] = $urandom % 1024;
                    else smp[sidx(a, p, k)] = (tgt + $urandom % 6) % 1024;
                end
            end
        end
    endtask

    int zoom_vals [8] = '{510, 510, 499, 510, 510, 1023, 510, 510};

    initial begin
        res = 1'b1;
        wr_en = 1'b0;
        data = '0;
        win_en = 1'b0;
        win_base = '0;
        peak_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_checks();
        res = 1'b0;

        fill_sent();
        for (int i = 0; i < ACQ * HITS; i++)
            smp[sidx(i / HITS, 1, i % HITS)] = 108;
        run(1'b0, 0, 1'b0, 1'b0, 1'b0);

        fill_sent();
        for (int a = 0; a < ACQ; a++) begin
            smp[sidx(a, 0, 0)] = 40;
            smp[sidx(a, 0, 1)] = 80;
        end
        run(1'b0, 0, 1'b1, 1'b0, 1'b0);

        fill_sent();
        for (int i = 0; i < ACQ * HITS; i++)
            smp[sidx(i / HITS, 1, i % HITS)] = 20 + $urandom % 4;
        run(1'b0, 0, 1'b0, 1'b0, 1'b0);

        fill_random();
        for (int i = 0; i < ACQ * HITS; i++)
            smp[sidx(i / HITS, 2, i % HITS)] = zoom_vals[i];
        run(1'b1, 500, 1'b1, 1'b0, 1'b0);

        fill_random();
        run(1'b0, 0, 1'b1, 1'b1, 1'b1);

        fill_sent();
        run(1'b1, $urandom % 1024, 1'b0, 1'b0, 1'b1);

        fill_random();
        send_hist(1'b0, 0, 1'b0);
        repeat (100) begin
            @(negedge clk);
            chk("drop_scan", 32'(drop), 32'(exp_drop));
            chk("acc_scan", 32'(accepting), 0);
            wr_en = 1'b0;
            exp_drop = 1'b0;
        end
        res = 1'b1;
        @(negedge clk);
        rst_checks();
        res = 1'b0;

        fill_random();
        run(1'b0, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            fill_random();
            run(1'($urandom), $urandom % 900, 1'($urandom),
                1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
